// File: rtl/sd_cmd_issue_ctrl.sv
// SD command issue controller: captures a command request, hands it to the serial stage,
// watches for the response or a timeout, and records sticky completion/error status.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start_i; command/setting outputs hold last command
// S_ISSUE | start_xfr_o high for this single cycle; timeout counter cleared
// S_WAIT  | waiting for finish_i; timeout counter running
// S_DONE  | one cycle: latch response, raise completion/error status
module sd_cmd_issue_ctrl #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [5:0]           cmd_index_i,
  input  logic [31:0]          argument_i,
  input  logic [1:0]           resp_type_i,
  input  logic                 check_crc_i,
  input  logic                 check_idx_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 int_clr_i,
  input  logic                 finish_i,
  input  logic                 crc_ok_i,
  input  logic                 index_ok_i,
  input  logic [119:0]         response_i,
  output logic                 start_xfr_o,
  output logic [1:0]           setting_o,
  output logic [39:0]          cmd_o,
  output logic                 busy_o,
  output logic [119:0]         response_o,
  output logic [4:0]           int_status_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  localparam logic [TIMEOUT_W-1:0] TCNT_ONE = TIMEOUT_W'(1);

  state_e               state_q;
  logic [TIMEOUT_W-1:0] tcnt_q;
  logic                 chk_crc_q;
  logic                 chk_idx_q;
  logic                 start_xfr_q;
  logic                 busy_q;
  logic [1:0]           setting_q;
  logic [39:0]          cmd_q;
  logic [119:0]         response_q;
  logic [4:0]           int_status_q;
  logic [4:0]           int_status_d;
  logic [4:0]           status_set;
  logic                 timeout_hit;

  // finish_i has priority: a timeout is only taken when no finish arrives in the same cycle
  assign timeout_hit = (state_q == S_WAIT) && !finish_i && setting_q[0] &&
                       (timeout_i != '0) && (tcnt_q == timeout_i);

  always_comb begin
    status_set = '0;
    if (timeout_hit) begin
      status_set[2] = 1'b1;
      status_set[1] = 1'b1;
    end else if (state_q == S_DONE) begin
      status_set[0] = 1'b1;
      status_set[3] = setting_q[0] && chk_crc_q && !crc_ok_i;
      status_set[4] = setting_q[0] && chk_idx_q && !index_ok_i;
      status_set[1] = status_set[3] | status_set[4];
    end
    // a bit being set in the same cycle as int_clr_i stays set
    int_status_d = (int_status_q & ~{5{int_clr_i}}) | status_set;
  end

  always_ff @(posedge sd_clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      tcnt_q       <= '0;
      chk_crc_q    <= 1'b0;
      chk_idx_q    <= 1'b0;
      start_xfr_q  <= 1'b0;
      busy_q       <= 1'b0;
      setting_q    <= '0;
      cmd_q        <= '0;
      response_q   <= '0;
      int_status_q <= '0;
    end else begin
      int_status_q <= int_status_d;
      start_xfr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cmd_q       <= {2'b01, cmd_index_i, argument_i};
            setting_q   <= {resp_type_i == 2'b11, resp_type_i != 2'b00};
            chk_crc_q   <= check_crc_i;
            chk_idx_q   <= check_idx_i;
            start_xfr_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tcnt_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (finish_i) begin
            state_q <= S_DONE;
          end else if (timeout_hit) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (tcnt_q != '1) begin
            tcnt_q <= tcnt_q + TCNT_ONE;
          end
        end
        S_DONE: begin
          if (setting_q[0]) begin
            response_q <= response_i;
          end
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign start_xfr_o  = start_xfr_q;
  assign setting_o    = setting_q;
  assign cmd_o        = cmd_q;
  assign busy_o       = busy_q;
  assign response_o   = response_q;
  assign int_status_o = int_status_q;

endmodule

// File: tb/tb_sd_cmd_issue_ctrl.sv
// Randomized scoreboard bench for sd_cmd_issue_ctrl: the driver predicts each command's
// outcome from the command rules and queues it; a monitor checks issue pulses and completions.
module tb_sd_cmd_issue_ctrl;
  localparam int TW = 16;

  logic          sd_clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [5:0]    cmd_index_i;
  logic [31:0]   argument_i;
  logic [1:0]    resp_type_i;
  logic          check_crc_i;
  logic          check_idx_i;
  logic [TW-1:0] timeout_i;
  logic          int_clr_i;
  logic          finish_i;
  logic          crc_ok_i;
  logic          index_ok_i;
  logic [119:0]  response_i;
  logic          start_xfr_o;
  logic [1:0]    setting_o;
  logic [39:0]   cmd_o;
  logic          busy_o;
  logic [119:0]  response_o;
  logic [4:0]    int_status_o;

  sd_cmd_issue_ctrl #(.TIMEOUT_W(TW)) dut (
    .sd_clk(sd_clk), .rst(rst), .start_i(start_i), .cmd_index_i(cmd_index_i),
    .argument_i(argument_i), .resp_type_i(resp_type_i), .check_crc_i(check_crc_i),
    .check_idx_i(check_idx_i), .timeout_i(timeout_i), .int_clr_i(int_clr_i),
    .finish_i(finish_i), .crc_ok_i(crc_ok_i), .index_ok_i(index_ok_i),
    .response_i(response_i), .start_xfr_o(start_xfr_o), .setting_o(setting_o),
    .cmd_o(cmd_o), .busy_o(busy_o), .response_o(response_o), .int_status_o(int_status_o)
  );

  always #5 sd_clk = ~sd_clk;

  typedef struct {
    logic [4:0]   status;
    logic [119:0] resp;
    logic [39:0]  cmd;
    logic [1:0]   setting;
    int           len;
  } done_t;

  typedef struct {
    logic [39:0] cmd;
    logic [1:0]  setting;
  } iss_t;

  done_t        done_q[$];
  iss_t         iss_q[$];
  int           checks = 0;
  int           failures = 0;
  logic [4:0]   exp_status;
  logic [119:0] exp_resp;

  bit    m_prev_busy;
  bit    m_prev_xfr;
  int    m_len;
  done_t m_d;
  iss_t  m_i;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  // monitor: issue pulses and command completions (busy_o falling)
  initial begin
    m_prev_busy = 0;
    m_prev_xfr  = 0;
    m_len       = 0;
    forever begin
      @(negedge sd_clk);
      if (!rst) begin
        m_prev_busy = 0;
        m_prev_xfr  = 0;
        m_len       = 0;
      end else begin
        if (start_xfr_o) begin
          chk("xfr_single_pulse", 128'(m_prev_xfr), 128'(0));
          if (!m_prev_xfr) begin
            if (iss_q.size() == 0) flag_fail("xfr_unexpected");
            else begin
              m_i = iss_q.pop_front();
              chk("issue_cmd", 128'(cmd_o), 128'(m_i.cmd));
              chk("issue_setting", 128'(setting_o), 128'(m_i.setting));
            end
          end
        end
        if (busy_o) m_len++;
        else if (m_prev_busy) begin
          if (done_q.size() == 0) flag_fail("done_unexpected");
          else begin
            m_d = done_q.pop_front();
            chk("done_status", 128'(int_status_o), 128'(m_d.status));
            chk("done_response", 128'(response_o), 128'(m_d.resp));
            chk("done_cmd", 128'(cmd_o), 128'(m_d.cmd));
            chk("done_setting", 128'(setting_o), 128'(m_d.setting));
            chk("busy_cycles", 128'(m_len), 128'(m_d.len));
          end
          m_len = 0;
        end
        m_prev_busy = busy_o;
        m_prev_xfr  = start_xfr_o;
      end
    end
  end

  // T: timeout_i value; f: WAIT cycle (0-based) in which finish_i is pulsed
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input bit ccrc, input bit cidx, input bit crcok, input bit idxok,
                         input int t, input int f, input bit inj, input bit clr_before,
                         input bit coinc);
    logic [127:0] rr;
    logic [4:0]   nb;
    bit           resp_exp, to, crce, cie, coinc_eff;
    done_t        d;
    iss_t         is;
    rr = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (clr_before) begin
      int_clr_i = 1'b1;
      @(negedge sd_clk);
      int_clr_i = 1'b0;
      exp_status = '0;
    end
    resp_exp  = (rt != 2'b00);
    to        = resp_exp && (t != 0) && (t < f);
    coinc_eff = coinc && !to;
    is.cmd     = {2'b01, idx, arg};
    is.setting = {rt == 2'b11, resp_exp};
    if (to) begin
      nb    = 5'b00110;
      d.len = t + 2;
    end else begin
      crce  = resp_exp && ccrc && !crcok;
      cie   = resp_exp && cidx && !idxok;
      nb    = {cie, crce, 1'b0, crce | cie, 1'b1};
      d.len = f + 3;
      if (resp_exp) exp_resp = rr[119:0];
      if (coinc_eff) exp_status = '0;
    end
    exp_status = exp_status | nb;
    d.status  = exp_status;
    d.resp    = exp_resp;
    d.cmd     = is.cmd;
    d.setting = is.setting;
    iss_q.push_back(is);
    done_q.push_back(d);

    cmd_index_i = idx;
    argument_i  = arg;
    resp_type_i = rt;
    check_crc_i = ccrc;
    check_idx_i = cidx;
    crc_ok_i    = crcok;
    index_ok_i  = idxok;
    timeout_i   = TW'(t);
    response_i  = rr[119:0];
    start_i     = 1'b1;
    @(negedge sd_clk);
    start_i = 1'b0;
    chk("start_latency", 128'(start_xfr_o), 128'(1));
    chk("busy_in_issue", 128'(busy_o), 128'(1));
    finish_i = 1'($urandom % 2);
    for (int k = 0; k <= f; k++) begin
      @(negedge sd_clk);
      start_i  = inj && (k == 0);
      finish_i = (k == f);
      if (inj && k == 0) begin
        cmd_index_i = ~idx;
        argument_i  = ~arg;
        resp_type_i = ~rt;
      end
    end
    @(negedge sd_clk);
    start_i   = 1'b0;
    finish_i  = 1'b0;
    int_clr_i = coinc_eff;
    @(negedge sd_clk);
    int_clr_i = 1'b0;
    for (int i = 0; i < 200 && busy_o; i++) @(negedge sd_clk);
    chk("busy_release", 128'(busy_o), 128'(0));
    @(negedge sd_clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_start_xfr"}, 128'(start_xfr_o), 128'(0));
    chk({tag, "_setting"}, 128'(setting_o), 128'(0));
    chk({tag, "_cmd"}, 128'(cmd_o), 128'(0));
    chk({tag, "_busy"}, 128'(busy_o), 128'(0));
    chk({tag, "_response"}, 128'(response_o), 128'(0));
    chk({tag, "_status"}, 128'(int_status_o), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    start_i = 0; cmd_index_i = 0; argument_i = 0; resp_type_i = 0; check_crc_i = 0;
    check_idx_i = 0; timeout_i = 0; int_clr_i = 0; finish_i = 0; crc_ok_i = 0;
    index_ok_i = 0; response_i = '0;
    exp_status = '0;
    exp_resp   = '0;
    repeat (3) @(negedge sd_clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge sd_clk);

    run_cmd(6'd17, 32'h0000_0200, 2'b01, 1, 1, 1, 1, 0, 60, 0, 1, 0);
    chk("cmd17_value", 128'(cmd_o), 128'(40'h51_0000_0200));
    run_cmd(6'd0, 32'h0, 2'b00, 1, 1, 0, 0, 5, 20, 0, 1, 0);
    chk("cmd0_value", 128'(cmd_o), 128'(40'h40_0000_0000));
    run_cmd(6'd8, 32'h1AA, 2'b01, 0, 0, 1, 1, 100, 130, 0, 1, 0);
    run_cmd(6'd2, 32'h0, 2'b11, 1, 0, 0, 1, 0, 10, 0, 1, 0);
    run_cmd(6'd2, 32'h0, 2'b11, 0, 0, 0, 1, 0, 10, 0, 1, 0);
    run_cmd(6'd3, 32'h0, 2'b10, 1, 1, 1, 0, 0, 7, 0, 1, 0);
    run_cmd(6'd9, 32'h1234_5678, 2'b01, 1, 0, 0, 1, 0, 12, 1, 1, 0);
    run_cmd(6'd13, 32'h0001_0000, 2'b01, 0, 0, 1, 1, 0, 4, 0, 0, 1);
    run_cmd(6'd7, 32'h0, 2'b01, 0, 0, 1, 1, 10, 10, 0, 1, 0);
    run_cmd(6'd7, 32'h0, 2'b01, 0, 0, 1, 1, 10, 11, 0, 1, 0);
    run_cmd(6'd7, 32'h0, 2'b01, 0, 0, 1, 1, 1, 5, 0, 0, 0);
    run_cmd(6'd55, 32'h0, 2'b01, 0, 0, 1, 1, 0, 0, 0, 0, 0);

    // reset in the middle of WAIT
    begin
      iss_t is;
      is.cmd = {2'b01, 6'd24, 32'hDEAD_BEEF};
      is.setting = 2'b01;
      iss_q.push_back(is);
      cmd_index_i = 6'd24; argument_i = 32'hDEAD_BEEF; resp_type_i = 2'b01;
      timeout_i = '0; start_i = 1'b1;
      @(negedge sd_clk);
      start_i = 1'b0;
      repeat (6) @(negedge sd_clk);
      #2 rst = 1'b0;
      #1 check_all_zero("midreset");
      exp_status = '0;
      exp_resp   = '0;
      @(negedge sd_clk);
      rst = 1'b1;
      repeat (2) @(negedge sd_clk);
      chk("post_reset_status", 128'(int_status_o), 128'(0));
      chk("post_reset_busy", 128'(busy_o), 128'(0));
    end
    run_cmd(6'd17, 32'h0000_0400, 2'b01, 1, 1, 1, 1, 50, 8, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int t;
      t = ($urandom % 3 == 0) ? 0 : int'($urandom_range(1, 45));
      run_cmd(6'($urandom), $urandom, 2'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), t, int'($urandom_range(0, 40)),
              ($urandom % 4) == 0, 1'($urandom), ($urandom % 3) == 0);
    end

    repeat (4) @(negedge sd_clk);
    chk("done_queue_drained", 128'(done_q.size()), 128'(0));
    chk("issue_queue_drained", 128'(iss_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
